jtopl_mmr: RTL and testbench

- CPU-side register front end for the OPL core.
- Turns two-port bus writes into held update strobes and slot/channel selectors for the per-operator/per-channel register stage; register pair: address port and data port.
- Owns global registers: rhythm, AM/vibrato depth, wave-select enable.
- Holds each per-slot update across a full 18-slot round so the register stage captures it exactly once, and reports busy to the CPU.

---
 rtl/jtopl_pkg.sv | 36 +++
 rtl/jtopl_mmr_dec.sv | 60 ++++++
 rtl/jtopl_mmr.sv | 169 ++++++++++++++++
 tb/tb_jtopl_mmr.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/jtopl_pkg.sv
// Shared definitions for the OPL CPU register front end: register bases,
// update FSM encoding and the index of each one-hot update strobe.
package jtopl_pkg;

  localparam logic [7:0] REG_TEST   = 8'h01;
  localparam logic [7:0] REG_MULT   = 8'h20;
  localparam logic [7:0] REG_KSL_TL = 8'h40;
  localparam logic [7:0] REG_AR_DR  = 8'h60;
  localparam logic [7:0] REG_SL_RR  = 8'h80;
  localparam logic [7:0] REG_FNUMLO = 8'hA0;
  localparam logic [7:0] REG_FNUMHI = 8'hB0;
  localparam logic [7:0] REG_RHY    = 8'hBD;
  localparam logic [7:0] REG_FBCON  = 8'hC0;
  localparam logic [7:0] REG_WAV    = 8'hE0;

  localparam int NUM_UP = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR    = 2'd1,
    ST_WAIT0 = 2'd2,
    ST_WAIT1 = 2'd3
  } mmr_state_e;

  typedef enum logic [2:0] {
    UP_MULT   = 3'd0,
    UP_KSL_TL = 3'd1,
    UP_AR_DR  = 3'd2,
    UP_SL_RR  = 3'd3,
    UP_WAV    = 3'd4,
    UP_FNUMLO = 3'd5,
    UP_FNUMHI = 3'd6,
    UP_FBCON  = 3'd7
  } up_idx_e;

endpackage

// File: rtl/jtopl_mmr_dec.sv
// Combinational decoder: latched register address to slot/channel update
// target, plus flags for the two global registers.
module jtopl_mmr_dec
  import jtopl_pkg::*;
#(
  parameter int OPL_TYPE = 1
) (
  input  logic [7:0] addr_i,
  output logic       valid_o,
  output up_idx_e    up_o,
  output logic [1:0] group_o,
  output logic [2:0] sub_o,
  output logic [3:0] ch_o,
  output logic       is_rhy_o,
  output logic       is_test_o
);

  logic op_ok;
  logic ch_ok;

  always_comb begin
    op_ok     = (addr_i[4:3] != 2'd3) && (addr_i[2:0] < 3'd6);
    ch_ok     = addr_i[3:0] < 4'd9;
    valid_o   = 1'b0;
    up_o      = UP_MULT;
    group_o   = addr_i[4:3];
    sub_o     = addr_i[2:0];
    ch_o      = addr_i[3:0];
    is_rhy_o  = addr_i == REG_RHY;
    is_test_o = addr_i == REG_TEST;

    // Operator registers occupy 32-byte windows; channel registers 16-byte ones.
    if (addr_i[7:5] == REG_MULT[7:5]) begin
      valid_o = op_ok;
      up_o    = UP_MULT;
    end else if (addr_i[7:5] == REG_KSL_TL[7:5]) begin
      valid_o = op_ok;
      up_o    = UP_KSL_TL;
    end else if (addr_i[7:5] == REG_AR_DR[7:5]) begin
      valid_o = op_ok;
      up_o    = UP_AR_DR;
    end else if (addr_i[7:5] == REG_SL_RR[7:5]) begin
      valid_o = op_ok;
      up_o    = UP_SL_RR;
    end else if (addr_i[7:5] == REG_WAV[7:5]) begin
      valid_o = op_ok && (OPL_TYPE != 1);
      up_o    = UP_WAV;
    end else if (addr_i[7:4] == REG_FNUMLO[7:4]) begin
      valid_o = ch_ok;
      up_o    = UP_FNUMLO;
    end else if (addr_i[7:4] == REG_FNUMHI[7:4]) begin
      valid_o = ch_ok;
      up_o    = UP_FNUMHI;
    end else if (addr_i[7:4] == REG_FBCON[7:4]) begin
      valid_o = ch_ok;
      up_o    = UP_FBCON;
    end
  end

endmodule

// File: rtl/jtopl_mmr.sv
// CPU register front end: edge-detects bus writes, owns the global registers
// and holds each slot/channel update for one full slot round.
module jtopl_mmr
  import jtopl_pkg::*;
#(
  parameter int OPL_TYPE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       zero,
  input  logic       addr,
  input  logic [7:0] cpu_din,
  input  logic       cs_n,
  input  logic       wr_n,
  output logic       busy,
  output logic       wr_lost,
  output logic       write,
  output logic [7:0] din,
  output logic [3:0] sel_ch,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic       up_mult,
  output logic       up_ksl_tl,
  output logic       up_ar_dr,
  output logic       up_sl_rr,
  output logic       up_wav,
  output logic       up_fnumlo,
  output logic       up_fnumhi,
  output logic       up_fbcon,
  output logic       rhy_en,
  output logic [4:0] rhy_kon,
  output logic       am_dep,
  output logic       vib_dep,
  output logic       wave_mode,
  output logic [1:0] fsm_st
);

  // Bus handshake: a write is the first clk with cs_n=0 and wr_n=0 after a
  // clk where either was high; a CPU holding both low counts only once.
  mmr_state_e st_q, st_d;
  logic              bus_idle_q;
  logic [7:0]        addr_q, addr_d, din_q, din_d;
  logic [3:0]        ch_q, ch_d;
  logic [1:0]        grp_q, grp_d;
  logic [2:0]        sub_q, sub_d;
  logic [NUM_UP-1:0] up_q, up_d;
  logic              lost_q, lost_d;
  logic [7:0]        glb_q, glb_d;
  logic              wave_q, wave_d;

  logic       wr_ev, addr_wr, data_wr, slot0;
  logic       dec_valid, dec_rhy, dec_test;
  up_idx_e    dec_up;
  logic [1:0] dec_group;
  logic [2:0] dec_sub;
  logic [3:0] dec_ch;

  jtopl_mmr_dec #(.OPL_TYPE(OPL_TYPE)) u_dec (
    .addr_i    (addr_q),
    .valid_o   (dec_valid),
    .up_o      (dec_up),
    .group_o   (dec_group),
    .sub_o     (dec_sub),
    .ch_o      (dec_ch),
    .is_rhy_o  (dec_rhy),
    .is_test_o (dec_test)
  );

  always_comb begin
    wr_ev   = ~cs_n & ~wr_n & bus_idle_q;
    addr_wr = wr_ev & ~addr;
    data_wr = wr_ev & addr;
    slot0   = cen & zero;
    st_d    = st_q;
    addr_d  = addr_wr ? cpu_din : addr_q;
    din_d   = din_q;
    ch_d    = ch_q;
    grp_d   = grp_q;
    sub_d   = sub_q;
    up_d    = up_q;
    glb_d   = glb_q;
    wave_d  = wave_q;
    lost_d  = data_wr && (st_q != ST_IDLE);

    case (st_q)
      ST_IDLE: begin
        if (data_wr) begin
          if (dec_valid) begin
            st_d  = ST_WR;
            din_d = cpu_din;
            up_d  = NUM_UP'(1) << dec_up;
            if (dec_up >= UP_FNUMLO) begin
              ch_d = dec_ch;
            end else begin
              grp_d = dec_group;
              sub_d = dec_sub;
            end
          end else if (dec_rhy) begin
            glb_d = cpu_din;
          end else if (dec_test && (OPL_TYPE != 1)) begin
            wave_d = cpu_din[5];
          end
        end
      end
      ST_WR:    st_d = ST_WAIT0;
      // Two slot-0 marks after WR guarantee a complete round was seen.
      ST_WAIT0: if (slot0) st_d = ST_WAIT1;
      ST_WAIT1: begin
        if (slot0) begin
          st_d = ST_IDLE;
          up_d = '0;
        end
      end
      default:  st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q       <= ST_IDLE;
      bus_idle_q <= 1'b0;
      addr_q     <= 8'h00;
      din_q      <= 8'h00;
      ch_q       <= 4'd0;
      grp_q      <= 2'd0;
      sub_q      <= 3'd0;
      up_q       <= '0;
      lost_q     <= 1'b0;
      glb_q      <= 8'h00;
      wave_q     <= 1'b0;
    end else begin
      st_q       <= st_d;
      bus_idle_q <= cs_n | wr_n;
      addr_q     <= addr_d;
      din_q      <= din_d;
      ch_q       <= ch_d;
      grp_q      <= grp_d;
      sub_q      <= sub_d;
      up_q       <= up_d;
      lost_q     <= lost_d;
      glb_q      <= glb_d;
      wave_q     <= wave_d;
    end
  end

  assign busy      = st_q != ST_IDLE;
  assign write     = st_q == ST_WR;
  assign wr_lost   = lost_q;
  assign din       = din_q;
  assign sel_ch    = ch_q;
  assign sel_group = grp_q;
  assign sel_sub   = sub_q;
  assign up_mult   = up_q[UP_MULT];
  assign up_ksl_tl = up_q[UP_KSL_TL];
  assign up_ar_dr  = up_q[UP_AR_DR];
  assign up_sl_rr  = up_q[UP_SL_RR];
  assign up_wav    = up_q[UP_WAV];
  assign up_fnumlo = up_q[UP_FNUMLO];
  assign up_fnumhi = up_q[UP_FNUMHI];
  assign up_fbcon  = up_q[UP_FBCON];
  assign am_dep    = glb_q[7];
  assign vib_dep   = glb_q[6];
  assign rhy_en    = glb_q[5];
  assign rhy_kon   = glb_q[4:0];
  assign wave_mode = wave_q;
  assign fsm_st    = st_q;

endmodule

// File: tb/tb_jtopl_mmr.sv
// Directed bench for jtopl_mmr: expected updates are queued when a write is
// driven and popped when the write pulse appears.
module tb_jtopl_mmr;

  localparam int OPL_TYPE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       zero = 1'b0;
  logic       addr = 1'b0;
  logic [7:0] cpu_din = 8'h00;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;

  logic       busy, wr_lost, write;
  logic [7:0] din;
  logic [3:0] sel_ch;
  logic [1:0] sel_group;
  logic [2:0] sel_sub;
  logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav, up_fnumlo, up_fnumhi, up_fbcon;
  logic       rhy_en, am_dep, vib_dep, wave_mode;
  logic [4:0] rhy_kon;
  logic [1:0] fsm_st;

  jtopl_mmr #(.OPL_TYPE(OPL_TYPE)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .addr(addr),
    .cpu_din(cpu_din), .cs_n(cs_n), .wr_n(wr_n),
    .busy(busy), .wr_lost(wr_lost), .write(write), .din(din),
    .sel_ch(sel_ch), .sel_group(sel_group), .sel_sub(sel_sub),
    .up_mult(up_mult), .up_ksl_tl(up_ksl_tl), .up_ar_dr(up_ar_dr), .up_sl_rr(up_sl_rr),
    .up_wav(up_wav), .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi), .up_fbcon(up_fbcon),
    .rhy_en(rhy_en), .rhy_kon(rhy_kon), .am_dep(am_dep), .vib_dep(vib_dep),
    .wave_mode(wave_mode), .fsm_st(fsm_st)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  // Packed update: {din, group, sub, ch, one-hot up vector}
  logic [24:0] exp_q[$];

  function automatic logic [7:0] up_vec();
    return {up_fbcon, up_fnumhi, up_fnumlo, up_wav, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult};
  endfunction

  function automatic logic [24:0] mk(input logic [7:0] d, input logic [1:0] g,
                                     input logic [2:0] s, input logic [3:0] c, input int up);
    logic [7:0] v;
    v = 8'd1 << up;
    return {d, g, s, c, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks; every call returns 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slot_zero();
    cen  = 1'b1;
    zero = 1'b1;
    tick();
    cen  = 1'b0;
    zero = 1'b0;
  endtask

  // One idle bus clk first so the following low strobe is seen as new.
  task automatic bus_wr(input logic a, input logic [7:0] d, input logic cz);
    cs_n = 1'b1;
    wr_n = 1'b1;
    tick();
    addr    = a;
    cpu_din = d;
    cs_n    = 1'b0;
    wr_n    = 1'b0;
    cen     = cz;
    zero    = cz;
    tick();
    cs_n = 1'b1;
    wr_n = 1'b1;
    cen  = 1'b0;
    zero = 1'b0;
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [7:0] d, input logic cz);
    bus_wr(1'b0, a, 1'b0);
    bus_wr(1'b1, d, cz);
  endtask

  // Scoreboard pop at the write pulse.
  task automatic pop_check(input string tag);
    logic [24:0] e;
    chk({tag, "_write"}, write, 1);
    chk({tag, "_pending"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_update"}, {din, sel_group, sel_sub, sel_ch, up_vec()}, e);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      slot_zero();
      n++;
    end
    chk({tag, "_idle_in_budget"}, busy, 0);
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_outs_a", {busy, wr_lost, write, din, sel_ch, sel_group, sel_sub}, 0);
    chk("reset_outs_b", {up_vec(), rhy_en, rhy_kon, am_dep, vib_dep, wave_mode, fsm_st}, 0);
    rst_n = 1'b1;
    tick();

    // Reset while parked in WAIT0 with up_ar_dr held
    exp_q.push_back(mk(8'h55, 2'd0, 3'd1, 4'd0, 2));
    reg_wr(8'h61, 8'h55, 1'b0);
    pop_check("ar_dr");
    tick();
    chk("ar_dr_wait0", {busy, write, up_ar_dr, fsm_st}, {1'b1, 1'b0, 1'b1, 2'd2});
    rst_n = 1'b0;
    tick();
    chk("midrst_a", {busy, wr_lost, write, din, sel_ch, sel_group, sel_sub}, 0);
    chk("midrst_b", {up_vec(), rhy_en, rhy_kon, am_dep, vib_dep, wave_mode, fsm_st}, 0);
    rst_n = 1'b1;
    tick();
    // Address latch cleared to 0x00, which is not a register: data is ignored
    bus_wr(1'b1, 8'hA5, 1'b0);
    chk("latch_zero_ignored", {busy, write, up_vec(), din}, 0);

    // 0x4D: KSL_TL group 1 sub 5; busy ends exactly on the 2nd slot-0 mark
    exp_q.push_back(mk(8'h3F, 2'd1, 3'd5, 4'd0, 1));
    reg_wr(8'h4D, 8'h3F, 1'b0);
    pop_check("ksl_tl");
    tick();
    chk("ksl_tl_held", {write, busy, up_vec(), din}, {1'b0, 1'b1, 8'h02, 8'h3F});
    slot_zero();
    chk("ksl_tl_first_zero", {busy, up_ksl_tl}, 2'b11);
    cen = 1'b1;
    repeat (3) tick();
    cen = 1'b0;
    chk("ksl_tl_cen_no_zero", {busy, up_ksl_tl}, 2'b11);
    slot_zero();
    chk("ksl_tl_done", {busy, write, up_vec()}, 0);

    // 0xB8 with cen&&zero coinciding with entry to WR: that mark is not counted
    exp_q.push_back(mk(8'h31, 2'd1, 3'd5, 4'd8, 6));
    reg_wr(8'hB8, 8'h31, 1'b1);
    pop_check("fnumhi");
    tick();
    slot_zero();
    chk("fnumhi_still_busy", {busy, up_fnumhi}, 2'b11);
    slot_zero();
    chk("fnumhi_done", {busy, up_vec()}, 0);

    // Invalid channel / sub / group offsets are ignored
    reg_wr(8'hB9, 8'h31, 1'b0);
    chk("b9_ignored", {busy, write, up_vec()}, 0);
    reg_wr(8'h26, 8'h11, 1'b0);
    chk("sub6_ignored", {busy, write, up_vec(), din}, {10'd0, 8'h31});
    reg_wr(8'h38, 8'h22, 1'b0);
    chk("group3_ignored", {busy, write, up_vec(), din}, {10'd0, 8'h31});

    // Global registers
    reg_wr(8'hBD, 8'hFF, 1'b0);
    chk("bd_ff", {am_dep, vib_dep, rhy_en, rhy_kon, busy}, {8'hFF, 1'b0});
    reg_wr(8'hBD, 8'h4A, 1'b0);
    chk("bd_4a", {am_dep, vib_dep, rhy_en, rhy_kon}, 8'h4A);
    reg_wr(8'h01, 8'h20, 1'b0);
    chk("wave_mode_set", {wave_mode, busy}, {(OPL_TYPE != 1), 1'b0});

    // Data write in WAIT1 is lost; address write while busy takes effect later
    exp_q.push_back(mk(8'h12, 2'd0, 3'd3, 4'd8, 4));
    reg_wr(8'hE3, 8'h12, 1'b0);
    pop_check("wav");
    tick();
    slot_zero();
    chk("wav_wait1", fsm_st, 3);
    bus_wr(1'b1, 8'h99, 1'b0);
    chk("lost_pulse", {wr_lost, up_vec(), din, fsm_st}, {1'b1, 8'h10, 8'h12, 2'd3});
    tick();
    chk("lost_one_clk", wr_lost, 0);
    bus_wr(1'b0, 8'hA2, 1'b0);
    chk("addr_wr_busy", {up_vec(), din, sel_ch, fsm_st}, {8'h10, 8'h12, 4'd8, 2'd3});
    bus_wr(1'b1, 8'hBD, 1'b0);
    chk("global_lost", {wr_lost, am_dep, vib_dep, rhy_en, rhy_kon}, {1'b1, 8'h4A});
    wait_idle("wav", 8);
    exp_q.push_back(mk(8'h77, 2'd0, 3'd3, 4'd2, 5));
    bus_wr(1'b1, 8'h77, 1'b0);
    pop_check("fnumlo_new_addr");
    wait_idle("fnumlo", 8);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
